// File: rtl/and_result_fifo.sv
// Small first-word-fall-through FIFO that buffers AND-gate result words between
// a valid/ready producer and a consumer that may stall, with zero and overflow flags.
module and_result_fifo #(
    parameter int data_width = 8,
    parameter int depth      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [data_width-1:0]      in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [data_width-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_zero,
    output logic [$clog2(depth):0]     count,
    output logic                       ovf_err,
    input  logic                       clr_err
);

    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w:0] full_count = depth[ptr_w:0];

    logic [data_width-1:0] mem [depth];
    logic [ptr_w-1:0]      wr_ptr;
    logic [ptr_w-1:0]      rd_ptr;
    logic                  push;
    logic                  pop;
    logic                  overflow;

    // Flow control depends only on the stored count, never on out_ready.
    assign in_ready  = (count != full_count);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign overflow  = in_valid && !in_ready;

    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign out_zero  = out_valid && (out_data == '0);

    // Storage carries no reset; out_data is masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (overflow) begin
            ovf_err <= 1'b1;
        end else if (clr_err) begin
            ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_and_result_fifo.sv
// Bench for and_result_fifo: fixed vector table, hand-written streaming and
// async-reset sequences, then random traffic against a queue-based reference.
module tb_and_result_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_zero;
    logic [2:0]    count;
    logic          ovf_err;
    logic          clr_err;

    int checks = 0;
    int errors = 0;

    and_result_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_zero(out_zero), .count(count), .ovf_err(ovf_err), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of accepted words plus the sticky flag.
    logic [DW-1:0] mq[$];
    logic          m_ovf;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic [DW-1:0] d, input logic v, input logic r, input logic c);
        bit full, empty;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        if (!empty && r) void'(mq.pop_front());
        if (v && !full) mq.push_back(d);
        if (v && full) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [DW-1:0] e_data, input logic e_valid,
                           input logic e_zero, input logic [2:0] e_cnt, input logic e_rdy,
                           input logic e_ovf);
        chk({tag, ".out_data"},  32'(out_data),  32'(e_data));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".out_zero"},  32'(out_zero),  32'(e_zero));
        chk({tag, ".count"},     32'(count),     32'(e_cnt));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".ovf_err"},   32'(ovf_err),   32'(e_ovf));
    endtask

    task automatic chk_model(input string tag);
        logic [DW-1:0] hd;
        logic          vld;
        vld = (mq.size() != 0);
        hd  = vld ? mq[0] : '0;
        chk_all(tag, hd, vld, vld && (hd == '0), 3'(mq.size()), mq.size() != DEPTH, m_ovf);
    endtask

    // Drive one cycle of inputs, let the edge happen, and step the model.
    task automatic cycle(input logic [DW-1:0] d, input logic v, input logic r, input logic c);
        in_data   = d;
        in_valid  = v;
        out_ready = r;
        clr_err   = c;
        @(posedge clk);
        model_step(d, v, r, c);
        #1;
    endtask

    typedef struct {
        logic [DW-1:0] id;
        logic          iv, ordy, clr;
        logic [DW-1:0] e_data;
        logic          e_valid, e_zero;
        logic [2:0]    e_cnt;
        logic          e_rdy, e_ovf;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [DW-1:0] id, input logic iv, input logic ordy, input logic clr,
                       input logic [DW-1:0] e_data, input logic e_valid, input logic e_zero,
                       input logic [2:0] e_cnt, input logic e_rdy, input logic e_ovf);
        vec_t v;
        v.id = id; v.iv = iv; v.ordy = ordy; v.clr = clr;
        v.e_data = e_data; v.e_valid = e_valid; v.e_zero = e_zero;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_ovf = e_ovf;
        tbl.push_back(v);
    endtask

    initial begin
        logic [DW-1:0] a, b;

        // single word, then drain
        add(8'hA5, 1, 0, 0, 8'hA5, 1, 0, 3'd1, 1, 0);
        add(8'h00, 0, 1, 0, 8'h00, 0, 0, 3'd0, 1, 0);
        // fill, overflow, full refuses push even with a pop, drain, clear
        add(8'h01, 1, 0, 0, 8'h01, 1, 0, 3'd1, 1, 0);
        add(8'h02, 1, 0, 0, 8'h01, 1, 0, 3'd2, 1, 0);
        add(8'h03, 1, 0, 0, 8'h01, 1, 0, 3'd3, 1, 0);
        add(8'h04, 1, 0, 0, 8'h01, 1, 0, 3'd4, 0, 0);
        add(8'hFF, 1, 0, 0, 8'h01, 1, 0, 3'd4, 0, 1);
        add(8'hFF, 1, 1, 0, 8'h02, 1, 0, 3'd3, 1, 1);
        add(8'h00, 0, 1, 0, 8'h03, 1, 0, 3'd2, 1, 1);
        add(8'h00, 0, 1, 0, 8'h04, 1, 0, 3'd1, 1, 1);
        add(8'h00, 0, 1, 0, 8'h00, 0, 0, 3'd0, 1, 1);
        add(8'h00, 0, 0, 1, 8'h00, 0, 0, 3'd0, 1, 0);
        // simultaneous push/pop at count 2
        add(8'h10, 1, 0, 0, 8'h10, 1, 0, 3'd1, 1, 0);
        add(8'h20, 1, 0, 0, 8'h10, 1, 0, 3'd2, 1, 0);
        add(8'h30, 1, 1, 0, 8'h20, 1, 0, 3'd2, 1, 0);
        add(8'h00, 0, 1, 0, 8'h30, 1, 0, 3'd1, 1, 0);
        add(8'h00, 0, 1, 0, 8'h00, 0, 0, 3'd0, 1, 0);
        // empty with out_ready high stays at zero
        add(8'h00, 0, 1, 0, 8'h00, 0, 0, 3'd0, 1, 0);
        // overflow and clear on the same edge: overflow wins
        add(8'h11, 1, 0, 0, 8'h11, 1, 0, 3'd1, 1, 0);
        add(8'h22, 1, 0, 0, 8'h11, 1, 0, 3'd2, 1, 0);
        add(8'h33, 1, 0, 0, 8'h11, 1, 0, 3'd3, 1, 0);
        add(8'h44, 1, 0, 0, 8'h11, 1, 0, 3'd4, 0, 0);
        add(8'hEE, 1, 0, 1, 8'h11, 1, 0, 3'd4, 0, 1);
        add(8'h00, 0, 0, 1, 8'h11, 1, 0, 3'd4, 0, 0);
        add(8'h00, 0, 1, 0, 8'h22, 1, 0, 3'd3, 1, 0);
        add(8'h00, 0, 1, 0, 8'h33, 1, 0, 3'd2, 1, 0);
        add(8'h00, 0, 1, 0, 8'h44, 1, 0, 3'd1, 1, 0);
        add(8'h00, 0, 1, 0, 8'h00, 0, 0, 3'd0, 1, 0);

        in_data = '0; in_valid = 0; out_ready = 0; clr_err = 0;
        rst_n = 0;
        model_reset();
        #3;
        chk_all("reset", 8'h00, 0, 0, 3'd0, 1, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (tbl[i]) begin
            cycle(tbl[i].id, tbl[i].iv, tbl[i].ordy, tbl[i].clr);
            chk_all($sformatf("vec%0d", i), tbl[i].e_data, tbl[i].e_valid, tbl[i].e_zero,
                    tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_ovf);
        end

        // zero detect from a&b
        a = 8'hF0; b = 8'h0F;
        cycle(a & b, 1, 0, 0);
        chk_all("zero_word", 8'h00, 1, 1, 3'd1, 1, 0);
        cycle(8'h00, 0, 1, 0);
        chk_all("zero_empty", 8'h00, 0, 0, 3'd0, 1, 0);

        // streaming with wrap-around
        for (int i = 0; i < 10; i++) begin
            cycle(8'(i), 1, 1, 0);
            chk($sformatf("stream%0d.out_data", i), 32'(out_data), 32'(i));
            chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
            chk($sformatf("stream%0d.ovf_err", i), 32'(ovf_err), 32'd0);
        end
        cycle(8'h00, 0, 1, 0);
        chk_all("stream_end", 8'h00, 0, 0, 3'd0, 1, 0);

        // asynchronous reset between edges
        cycle(8'hAA, 1, 0, 0);
        cycle(8'hBB, 1, 0, 0);
        cycle(8'hCC, 1, 0, 0);
        chk_all("pre_async", 8'hAA, 1, 0, 3'd3, 1, 0);
        in_valid = 0;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk_all("async_rst", 8'h00, 0, 0, 3'd0, 1, 0);
        #1;
        rst_n = 1;
        cycle(8'h55, 1, 0, 0);
        chk_all("post_rst", 8'h55, 1, 0, 3'd1, 1, 0);
        cycle(8'h00, 0, 1, 0);
        chk_model("post_rst_drain");

        // random traffic against the reference queue
        for (int i = 0; i < 400; i++) begin
            logic [DW-1:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = '0;
            cycle(d, 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
                  1'($urandom_range(0, 99) < 8));
            chk_model($sformatf("rand%0d", i));
        end

        in_valid = 0; out_ready = 0; clr_err = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_result_fifo.md
Name: and_result_fifo

Overview:
- Downstream stage for the bitwise AND gate. It captures the gate's data_width-bit result word into a small synchronous FIFO using a valid/ready handshake.
- It presents words to the consumer in first-word-fall-through order, with per-word zero detection and a sticky overflow flag.
- It decouples the combinational gate output from a consumer that may stall.

Parameters:
- data_width, 8, width of the result word (matches the AND gate output width).
- depth, 4, number of FIFO entries. Must be a power of two and at least 2.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  data_width  result word from the AND gate y output.
- in_valid  input  1  producer asserts when in_data is meaningful.
- in_ready  output  1  FIFO can accept a word this cycle.
- out_data  output  data_width  head-of-FIFO word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the head word this cycle.
- out_zero  output  1  head word is all zeros; only meaningful when out_valid=1.
- count  output  $clog2(depth)+1  number of stored words, 0..depth.
- ovf_err  output  1  sticky: a write was attempted while full.
- clr_err  input  1  synchronous clear of ovf_err.

Behaviour:
- Reset (rst_n=0, asynchronous): the following take effect immediately, independent of clk.
  - Read pointer, write pointer and count go to 0.
  - ovf_err goes to 0, out_valid to 0, out_data to 0, out_zero to 0, in_ready to 1.
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored words. The first push after rst_n deasserts is accepted normally.
- Push: occurs when in_valid=1 and in_ready=1 at a rising edge.
  - mem[wr_ptr] <= in_data.
  - wr_ptr increments modulo depth.
- Pop: occurs when out_valid=1 and out_ready=1 at a rising edge.
  - rd_ptr increments modulo depth.
- in_ready = (count != depth). It is derived from registered state only, with no combinational path from out_ready. A full FIFO refuses a push even if a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data = mem[rd_ptr] when out_valid=1, else 0 (first-word-fall-through).
- out_zero = out_valid AND (out_data == 0).
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N. Minimum latency is 1 cycle; there is no zero-cycle bypass when empty.
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
  - neither: unchanged.
- Empty with out_ready=1: no pop, and count never goes below 0.
- Full (count=depth): in_ready=0.
  - If in_valid=1 at an edge while in_ready=0, ovf_err <= 1. Data is dropped and the stored contents are unchanged.
- ovf_err clearing and priority:
  - clr_err=1 at an edge sets ovf_err <= 0.
  - If clr_err=1 and a new overflow occur at the same edge, the set wins and ovf_err=1.
- Pointer wrap-around: pointers are $clog2(depth) bits and wrap naturally. Full/empty are determined from count, not from pointer comparison.
- Ordering: strict FIFO; words exit in exactly the order they were accepted.

Test Plan:
1. Reset then single word:
   - Stimulus: assert rst_n=0, release; push in_data=8'hA5 with out_ready=0.
   - Required: after the edge, out_valid=1, out_data=8'hA5, count=1, out_zero=0, in_ready=1.
2. Fill to full and overflow:
   - Stimulus: push 8'h01, 8'h02, 8'h03, 8'h04 with out_ready=0, then hold in_valid=1 with in_data=8'hFF.
   - Required: count=4 and in_ready=0; ovf_err=1 after the next edge; draining yields 01, 02, 03, 04, and 8'hFF never appears.
   - Then pulse clr_err=1 for one cycle -> ovf_err=0.
3. Simultaneous push/pop at count=2:
   - Stimulus: holding 8'h10, 8'h20; push 8'h30 with out_ready=1.
   - Required: count stays 2 and out_data becomes 8'h20; the next pop yields 8'h30.
4. Zero detect:
   - Stimulus: push a&b = 8'hF0 & 8'h0F = 8'h00.
   - Required: out_valid=1, out_data=8'h00, out_zero=1.
   - With FIFO empty: out_zero=0, out_data=0.
5. Wrap-around streaming:
   - Stimulus: 10 consecutive words 0..9 with in_valid=1 and out_ready=1 every cycle.
   - Required: out_data sequence 0..9 in order with 1-cycle latency, count never exceeds 1, ovf_err stays 0.
6. Asynchronous reset mid-operation:
   - Stimulus: with count=3, drive rst_n=0 between clock edges.
   - Required: out_valid=0, count=0 and in_ready=1 immediately, without waiting for a clock edge; after release, pushing 8'h55 makes out_data=8'h55 after the edge.
